// File: rtl/shifter_pkg.sv
// Shared mode encoding and helpers for the pipelined barrel shifter.
// Modes 5-7 are reserved and pass the operand through unchanged.
package shifter_pkg;

  typedef enum logic [2:0] {
    MODE_ROL = 3'd0,
    MODE_ROR = 3'd1,
    MODE_SLL = 3'd2,
    MODE_SRL = 3'd3,
    MODE_SRA = 3'd4
  } shift_mode_t;

  function automatic logic is_rotate(input logic [2:0] m);
    return (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift/rotate by AMT plus an
// elastic register holding data, carry, shamt, mode and valid.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [2:0]       mode_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o,
  output logic [SHW-1:0]   shamt_o,
  output logic [2:0]       mode_o
);

  localparam int BIT = $clog2(AMT);

  logic [WIDTH-1:0] data_d, data_q;
  logic             carry_d, carry_q;
  logic             valid_q;
  logic [SHW-1:0]   shamt_q;
  logic [2:0]       mode_q;

  // Shift by AMT when this stage's shamt bit is set; shifts refresh carry.
  always_comb begin
    data_d  = data_i;
    carry_d = carry_i;
    if (shamt_i[BIT]) begin
      if (is_rotate(mode_i)) begin
        if (mode_i == MODE_ROL)
          data_d = {data_i[WIDTH-AMT-1:0],
                    data_i[WIDTH-1:WIDTH-AMT]};
        else
          data_d = {data_i[AMT-1:0],
                    data_i[WIDTH-1:AMT]};
      end else begin
        case (mode_i)
          MODE_SLL: begin
            data_d  = data_i << AMT;
            carry_d = data_i[WIDTH-AMT];
          end
          MODE_SRL: begin
            data_d  = data_i >> AMT;
            carry_d = data_i[AMT-1];
          end
          MODE_SRA: begin
            data_d  = $signed(data_i) >>> AMT;
            carry_d = data_i[AMT-1];
          end
          default: ;
        endcase
      end
    end
  end

  // Stage register; holds its contents while the load enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      shamt_q <= '0;
      mode_q  <= '0;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      carry_q <= carry_d;
      shamt_q <= shamt_i;
      mode_q  <= mode_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign carry_o = carry_q;
  assign shamt_o = shamt_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined multi-mode barrel shifter, one stage per shift-amount bit,
// with an elastic valid/ready chain that collapses bubbles.
module barrel_shift_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  logic [SHW:0]     vld;
  logic [SHW:0]     crr;
  logic [SHW:0]     ld;
  logic [WIDTH-1:0] dat [0:SHW];
  logic [SHW-1:0]   sht [0:SHW];
  logic [2:0]       mde [0:SHW];

  assign vld[0] = in_valid;
  assign crr[0] = 1'b0;
  assign dat[0] = in_data;
  assign sht[0] = in_shamt;
  assign mde[0] = in_mode;

  // A stage loads when it is empty or the stage after it loads.
  always_comb begin
    ld      = '0;
    ld[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--)
      ld[k] = !vld[k+1] || ld[k+1];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .AMT   (1 << k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load_i  (ld[k]),
      .valid_i (vld[k]),
      .data_i  (dat[k]),
      .carry_i (crr[k]),
      .shamt_i (sht[k]),
      .mode_i  (mde[k]),
      .valid_o (vld[k+1]),
      .data_o  (dat[k+1]),
      .carry_o (crr[k+1]),
      .shamt_o (sht[k+1]),
      .mode_o  (mde[k+1])
    );
  end

  assign in_ready  = ld[0] && !rst;
  assign out_valid = vld[SHW];
  assign out_data  = dat[SHW];
  assign out_carry = crr[SHW];

  logic unused;
  assign unused = ^{sht[SHW], mde[SHW]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe at WIDTH=8: directed mode
// sweep, streaming, backpressure and reset-in-flight scenarios.
module tb_barrel_shift_pipe;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [SHW-1:0] in_shamt;
  logic [2:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_carry;

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference: result and carry straight from the mode definitions.
  function automatic void model(input logic [W-1:0] d, input int s,
                                input int m, output logic [W-1:0] r,
                                output logic c);
    int u;
    int sg;
    u = int'(d);
    sg = d[W-1] ? u - (1 << W) : u;
    r = d;
    c = 1'b0;
    if (s == 0 || m > 4) return;
    case (m)
      0: r = W'((u << s) | (u >> (W - s)));
      1: r = W'((u >> s) | (u << (W - s)));
      2: begin r = W'(u << s); c = d[W-s]; end
      3: begin r = W'(u >> s); c = d[s-1]; end
      default: begin r = W'(sg >>> s); c = d[s-1]; end
    endcase
  endfunction

  task automatic send(input logic [W-1:0] d, input int s, input int m,
                      input logic [W-1:0] ed, input logic ec,
                      input bit lat, input bit want_rdy);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s[SHW-1:0];
    in_mode  = m[2:0];
    @(negedge clk);
    if (want_rdy) check("in_ready_stream", in_ready, 1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready 0 for %0d cycles", n);
    end else begin
      q.push_back('{ed, ec, cyc + 1, lat});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat, input bit want_rdy);
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic         c;
    int s;
    int m;
    d = W'($urandom);
    s = int'($urandom_range(0, W - 1));
    m = int'($urandom_range(0, 7));
    model(d, s, m, r, c);
    send(d, s, m, r, c, lat, want_rdy);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
    #1;
  endtask

  // Monitor: compare presented output with scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h c%0d want none",
                 out_data, out_carry);
      end else begin
        check("out_data", out_data, q[0].d);
        check("out_carry", out_carry, q[0].c);
        if (out_ready) begin
          if (q[0].lat)
            check("latency", cyc - q[0].acc + 1, SHW);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_shamt = '0;
    in_mode = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_carry", out_carry, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(8'h96, 3, 0, 8'hB4, 1'b0, 1, 0);
    send(8'h96, 3, 1, 8'hD2, 1'b0, 1, 0);
    send(8'h96, 1, 2, 8'h2C, 1'b1, 1, 0);
    send(8'h96, 4, 3, 8'h09, 1'b0, 1, 0);
    send(8'h96, 2, 4, 8'hE5, 1'b1, 1, 0);
    send(8'h80, 0, 4, 8'h80, 1'b0, 1, 0);
    send(8'h5A, 5, 6, 8'h5A, 1'b0, 1, 0);
    send(8'h01, 7, 2, 8'h80, 1'b0, 1, 0);
    drain();

    repeat (16) send_rand(1, 1);
    drain();

    repeat (4) send_rand(0, 1);
    out_ready = 1'b0;
    fork
      begin
        send_rand(0, 0);
        send_rand(0, 0);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    repeat (3) send_rand(0, 1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("rst_busy_in_ready", in_ready, 0);
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 0);
    check("flush_out_carry", out_carry, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send_rand(1, 1);
    drain();

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
